// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared memory-access types, LSU state encoding and alignment helper
package load_store_unit_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_access_t;

    typedef enum logic [1:0] {
        LSU_IDLE    = 2'd0,
        LSU_ACCESS  = 2'd1,
        LSU_RESPOND = 2'd2
    } lsu_state_t;

    function automatic logic mem_access_misaligned(input logic [1:0] addr, input mem_access_t access);
        return (access == MEM_HALF && addr[0]) || (access == MEM_WORD && addr != 2'd0);
    endfunction
endpackage

// File: rtl/load_store_unit_load_extender.sv
// lsu_load_extender: sign/zero extension of right-justified load data by access size
module lsu_load_extender
    import load_store_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] d_in,
    input  mem_access_t  access,
    input  logic         unsign,
    output logic [W-1:0] d_out
);
    always_comb begin
        d_out = access == MEM_BYTE ? (unsign ? {{(W-8){1'b0}}, d_in[7:0]} : {{(W-8){d_in[7]}}, d_in[7:0]}) :
                access == MEM_HALF ? (unsign ? {{(W-16){1'b0}}, d_in[15:0]} : {{(W-16){d_in[15]}}, d_in[15:0]}) :
                d_in;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: three-state load/store FSM with registered request/response; LSU_MISALIGN_CHECK_EN enables early misalignment faults
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  mem_access_t  req_access,
    input  logic         req_unsigned,
    input  logic [31:0]  req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_error,
    output logic [31:0]  bus_addr,
    output mem_access_t  bus_access,
    output logic         bus_wr_ena,
    output logic [W-1:0] bus_wr_data,
    input  logic [W-1:0] bus_rd_data,
    input  logic         bus_active
);
    lsu_state_t   state;
    logic [31:0]  addr_q;
    mem_access_t  access_q;
    logic         write_q;
    logic         unsign_q;
    logic [W-1:0] wdata_q;
    logic [W-1:0] ld_data;

    lsu_load_extender #(.W(W)) u_ext (
        .d_in  (bus_rd_data),
        .access(access_q),
        .unsign(unsign_q),
        .d_out (ld_data)
    );

    assign req_ready   = state == LSU_IDLE && !rst;
    assign rsp_valid   = state == LSU_RESPOND;
    assign bus_addr    = addr_q;
    assign bus_access  = access_q;
    assign bus_wr_data = wdata_q;
    // rst gates the strobe so an aborted store never reaches memory
    assign bus_wr_ena  = state == LSU_ACCESS && write_q && bus_active && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LSU_IDLE;
            addr_q    <= '0;
            access_q  <= MEM_WORD;
            write_q   <= 1'b0;
            unsign_q  <= 1'b0;
            wdata_q   <= '0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                LSU_IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    access_q <= req_access;
                    write_q  <= req_write;
                    unsign_q <= req_unsigned;
                    wdata_q  <= req_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
                    if (mem_access_misaligned(req_addr[1:0], req_access)) begin
                        state     <= LSU_RESPOND;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state <= LSU_ACCESS;
                    end
`else
                    state <= LSU_ACCESS;
`endif
                end
                LSU_ACCESS: begin
                    state     <= LSU_RESPOND;
                    rsp_error <= !bus_active;
                    rsp_rdata <= (write_q || !bus_active) ? '0 : ld_data;
                end
                LSU_RESPOND: if (rsp_ready) state <= LSU_IDLE;
                default: state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized transactions against a byte-array reference model
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    mem_access_t req_access = MEM_WORD;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] bus_addr;
    mem_access_t bus_access;
    logic        bus_wr_ena;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_active;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    logic [7:0] dev_mem [256];
    logic [7:0] ref_mem [256];

    load_store_unit #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_access(req_access), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .bus_addr(bus_addr),
        .bus_access(bus_access), .bus_wr_ena(bus_wr_ena), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_active(bus_active)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input int acc);
        return acc == 0 ? 1 : acc == 1 ? 2 : 4;
    endfunction

    // device: 256-byte little-endian memory, asynchronous read, garbage when unmapped
    assign bus_active = bus_addr < 32'd256;
    always_comb begin
        bus_rd_data = '0;
        for (int i = 0; i < 4; i++)
            if (i < nbytes(int'(bus_access))) bus_rd_data |= 32'(dev_mem[8'(bus_addr + 32'(i))]) << (8 * i);
        if (!bus_active) bus_rd_data = 32'hA5A5_5A5A;
    end

    always @(posedge clk) begin
        if (bus_wr_ena) begin
            wr_count++;
            if (bus_active)
                for (int i = 0; i < nbytes(int'(bus_access)); i++)
                    dev_mem[8'(bus_addr + 32'(i))] = bus_wr_data[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic wr, input int acc, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold);
        logic mapped, mis, early, exp_err;
        logic [31:0] exp_rd, v;
        int n, w0, exp_wr;
        n = nbytes(acc);
        mapped = addr < 32'd256;
        mis = (acc == 1 && addr[0]) || (acc == 2 && addr[1:0] != 2'd0);
        early = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        early = mis;
`endif
        exp_err = early || !mapped;
        exp_rd = '0;
        exp_wr = 0;
        if (!exp_err) begin
            if (wr) begin
                for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = wd[8*i +: 8];
                exp_wr = 1;
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v += 32'(ref_mem[8'(addr + 32'(i))]) * (32'd1 << (8 * i));
                if (!uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
                exp_rd = v;
            end
        end
        check("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_write = wr; req_access = mem_access_t'(acc);
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        w0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (early) begin
            check("early_rsp_valid", 32'(rsp_valid), 1);
        end else begin
            check("access_rsp_valid", 32'(rsp_valid), 0);
            check("access_req_ready", 32'(req_ready), 0);
            @(posedge clk); #1;
            check("latency_rsp_valid", 32'(rsp_valid), 1);
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", 32'(rsp_valid), 1);
            check("hold_req_ready", 32'(req_ready), 0);
            check("hold_rdata", rsp_rdata, exp_rd);
        end
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_error", 32'(rsp_error), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("done_rsp_valid", 32'(rsp_valid), 0);
        check("wr_pulses", 32'(wr_count - w0), 32'(exp_wr));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_error", 32'(rsp_error), 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_bus_wr_ena", 32'(bus_wr_ena), 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_access", 32'(bus_access), 32'(MEM_WORD));
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(1, 2, 0, 32'h10, 32'hDEADBEEF, 0);
        do_op(0, 2, 0, 32'h10, 32'h0, 0);
        check("word_load_val", rsp_rdata, 32'hDEADBEEF);
        do_op(1, 0, 0, 32'h20, 32'h80, 0);
        do_op(0, 0, 0, 32'h20, 32'h0, 0);
        do_op(0, 0, 1, 32'h20, 32'h0, 1);
        do_op(1, 1, 0, 32'h30, 32'h8001, 0);
        do_op(0, 1, 0, 32'h30, 32'h0, 0);
        do_op(0, 1, 1, 32'h30, 32'h0, 0);
        do_op(0, 2, 0, 32'hF000_0000, 32'h0, 0);
        do_op(1, 2, 0, 32'hF000_0000, 32'h1234_5678, 0);
        do_op(1, 2, 0, 32'h44, 32'hCAFEF00D, 5);
        do_op(0, 2, 0, 32'h44, 32'h0, 5);
        do_op(0, 2, 0, 32'h12, 32'h0, 0);
        do_op(1, 2, 0, 32'h12, 32'h0BAD_CAFE, 0);

        begin
            int w0;
            w0 = wr_count;
            req_valid = 1'b1; req_write = 1'b1; req_access = MEM_WORD;
            req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h1111_2222;
            @(posedge clk); #1;
            req_valid = 1'b0;
            rst = 1'b1;
            #1;
            check("abort_wr_ena", 32'(bus_wr_ena), 0);
            check("abort_req_ready", 32'(req_ready), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            check("abort_rsp_valid", 32'(rsp_valid), 0);
            check("abort_req_ready_after", 32'(req_ready), 1);
            check("abort_bus_addr", bus_addr, 0);
            check("abort_wr_pulses", 32'(wr_count - w0), 0);
            @(posedge clk); #1;
            check("abort_still_idle", 32'(rsp_valid), 0);
        end
        do_op(0, 2, 0, 32'h40, 32'h0, 0);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 255)) : 32'h8000_0000 + 32'($urandom_range(0, 4095));
            do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  a, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have one parameter: W, default 32, data width in bits (only 32 supported).
REQ-002 The port list SHALL be the following, clock and reset first:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_write  in  1  1=store, 0=load.
- req_access  in  mem_access_t  byte/half/word size.
- req_unsigned  in  1  load is zero-extended.
- req_addr  in  32  byte address.
- req_wdata  in  W  store data, right-justified.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  W  load result, extended; 0 for stores and errors.
- rsp_error  out  1  access fault.
- bus_addr  out  32  memory bus address.
- bus_access  out  mem_access_t  memory bus size.
- bus_wr_ena  out  1  memory bus write strobe.
- bus_wr_data  out  W  memory bus write data, unshifted.
- bus_rd_data  in  W  resolved tristate bus data, zero-extended and right-justified.
- bus_active  in  1  OR of all device address-decode hits.

Function
REQ-003 States SHALL be IDLE, ACCESS and RESPOND.
REQ-004 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-005 When req_valid&req_ready, the LSU SHALL register addr, access, write, unsigned and wdata, then go to ACCESS.
REQ-006 bus_addr, bus_access and bus_wr_data SHALL be driven from the registered request in every state.
REQ-007 bus_wr_ena SHALL be 1 only in ACCESS when the registered write=1 and bus_active=1.
REQ-008 ACCESS SHALL last exactly one cycle. The memory read is asynchronous, so bus_rd_data is sampled at the end of ACCESS.
REQ-009 Leaving ACCESS to RESPOND, the LSU SHALL register rsp_error = ~bus_active.
REQ-010 Leaving ACCESS to RESPOND, the LSU SHALL register rsp_rdata as follows:
- store or error: 0.
- load byte, signed: {{24{d[7]}},d[7:0]}.
- load half, signed: {{16{d[15]}},d[15:0]}.
- load unsigned, or word: the zero-extended value of d, with upper bits masked by size.
REQ-011 In RESPOND, rsp_valid SHALL be 1. rsp_rdata and rsp_error SHALL be held stable until rsp_valid&rsp_ready.
REQ-012 On rsp_valid&rsp_ready the LSU SHALL return to IDLE. A new request is accepted no earlier than the following cycle; throughput is one access per 3 cycles minimum.
REQ-013 Load latency from accept to rsp_valid SHALL be 2 cycles.
REQ-014 A stalled rsp_ready SHALL stall indefinitely, with no bus write repeated and no bus_wr_ena.
REQ-015 An unmapped address (bus_active=0) SHALL complete with rsp_error=1 and no write side-effect.

Reset
REQ-016 When rst=1 at a clock edge, the following SHALL hold the next cycle:
- state IDLE.
- rsp_valid, rsp_error, bus_wr_ena all 0.
- rsp_rdata 0.
- registered addr/wdata 0, access=word.
REQ-017 req_ready SHALL be 0 while rst=1.
REQ-018 rst asserted in ACCESS or RESPOND SHALL abort the operation with no response.
REQ-019 rst asserted in ACCESS SHALL force bus_wr_ena to 0 in that cycle (combinational gate on rst).

Configuration
REQ-020 Macro LSU_MISALIGN_CHECK_EN SHALL enable an alignment check.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, goes IDLE->RESPOND directly with rsp_error=1 and rsp_rdata=0. bus_wr_ena is never asserted for that request.
- Undefined: misaligned requests proceed through ACCESS unchanged. The memory's shifters define the result.

Structure
REQ-021 mem_access_t SHALL remain in the shared memory-access package.
REQ-022 The shared package SHALL gain the following:
- lsu_state_t enum.
- Function mem_access_misaligned(addr[1:0], access).
REQ-023 Sign/zero extension SHALL be a combinational sub-module lsu_load_extender (d_in, access, unsign -> d_out), reusable by other load paths.
REQ-024 The top module SHALL hold the FSM, request/response registers and bus drive.

Verification
REQ-025 Word store then load:
- Store 0xDEADBEEF @0x10 with bus_active=1: bus_wr_ena pulses exactly one cycle, rsp_error=0.
- Subsequent word load @0x10: rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
REQ-026 Signed and unsigned byte loads with bus_rd_data=0x00000080:
- Signed byte load: rsp_rdata=0xFFFFFF80.
- req_unsigned=1: rsp_rdata=0x00000080.
- Signed half load with 0x00008001: rsp_rdata=0xFFFF8001.
REQ-027 Unmapped access: load @0xF000_0000 with bus_active=0 -> rsp_error=1, rsp_rdata=0. Same as a store -> bus_wr_ena never 1.
REQ-028 Backpressure: hold rsp_ready=0 for 5 cycles -> the following hold with no second write:
- rsp_valid stays 1.
- rsp_rdata is stable.
- req_ready stays 0.
REQ-029 Misaligned word load @0x12:
- With LSU_MISALIGN_CHECK_EN: rsp_error=1 one cycle after accept, with no ACCESS state.
- Without it: ACCESS occurs and rsp_error=bus_active inverse.
REQ-030 Reset mid-operation: assert rst during ACCESS of a store -> bus_wr_ena=0 that cycle, then IDLE with rsp_valid=0 and req_ready=1 after rst deasserts.
